// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-lite encodings, slave FSM states and byte-lane strobe helper
package ahb_lite_pkg;
   typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;
   localparam int HRESP_OKAY = 0;
   localparam int HRESP_ERROR = 1;
   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
   // Contiguous run of 2**size lanes starting at the byte offset, little-endian.
   function automatic logic [7:0] byte_en(input logic [2:0] size, input logic [2:0] lane);
      return 8'(((9'd1 << (4'd1 << size)) - 9'd1) << lane);
   endfunction
endpackage

// File: rtl/ahb_sram_bytemem.sv
// ahb_sram_bytemem: DEPTH x DW word memory with per-byte write strobes and an asynchronous read port
module ahb_sram_bytemem #(
   parameter int DW = 32,
   parameter int DEPTH = 256,
   parameter int IW = 8
) (
   input  logic            hclk,
   input  logic            we,
   input  logic [IW-1:0]   addr,
   input  logic [DW/8-1:0] wstrb,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge hclk)
      for (int i = 0; i < DW/8; i++)
         if (we && wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   assign rdata = mem[addr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-lite SRAM responder with programmable wait states and two-cycle ERROR responses
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int RW = 2,
   parameter int DEPTH = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          hsel,
   input  logic [AW-1:0] haddr,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [2:0]    hsize,
   input  logic [2:0]    hburst,
   input  logic [3:0]    hprot,
   input  logic [DW-1:0] hwdata,
   input  logic          error,
   output logic [DW-1:0] hrdata,
   output logic          hready,
   output logic [RW-1:0] hresp
);
   localparam int BL = $clog2(DW/8);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic ok_dp, a_write, cap, bad;
   logic [IW-1:0] a_idx;
   logic [BL-1:0] a_lane, amask;
   logic [2:0] a_size;
   logic [DW-1:0] rdata;
   logic unused;
   assign unused = ^{hburst, hprot};
   assign amask = BL'((1 << hsize) - 1);
   assign bad = error || haddr[AW-1:BL] >= (AW-BL)'(DEPTH) || hsize > 3'(BL) || |(haddr[BL-1:0] & amask);
   always_comb begin
      hready = !(state == WAIT || state == ERR1);
      hresp = (state == ERR1 || state == ERR2) ? RW'(HRESP_ERROR) : RW'(HRESP_OKAY);
      cap = hsel && hready && htrans[1];
      state_n = state;
      cnt_n = cnt;
      if (state == WAIT) begin
         cnt_n = cnt - 4'd1;
         state_n = cnt == 4'd1 ? IDLE : WAIT;
      end else if (state == ERR1) begin
         state_n = ERR2;
      end else if (cap) begin
         state_n = bad ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
         cnt_n = 4'(WAIT_STATES);
      end else begin
         state_n = IDLE;
      end
   end
   // ok_dp marks an OKAY data phase in flight; it only changes when the bus is ready.
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) begin
         state <= IDLE;
         cnt <= '0;
         ok_dp <= 1'b0;
         a_write <= 1'b0;
         a_idx <= '0;
         a_lane <= '0;
         a_size <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (hready) ok_dp <= cap && !bad;
         if (cap) begin
            a_write <= hwrite;
            a_idx <= haddr[BL +: IW];
            a_lane <= haddr[BL-1:0];
            a_size <= hsize;
         end
      end
   ahb_sram_bytemem #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_mem (
      .hclk  (hclk),
      .we    (ok_dp && a_write && hready),
      .addr  (a_idx),
      .wstrb ((DW/8)'(byte_en(a_size, 3'(a_lane)))),
      .wdata (hwdata),
      .rdata (rdata)
   );
   assign hrdata = (ok_dp && !a_write) ? rdata : '0;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: pipelined AHB-lite master with a transfer-level reference model, WAIT_STATES 0 and 2
module tb_ahb_lite_sram_slave;
   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic        err;
      logic [31:0] addr;
      logic [31:0] data;
   } tr_t;
   localparam logic [1:0] NS = 2'b10;
   logic hclk = 1'b0;
   logic hresetn;
   logic [1:0] hsel, hwrite, error, hready;
   logic [1:0][31:0] haddr, hwdata, hrdata;
   logic [1:0][1:0] htrans, hresp;
   logic [1:0][2:0] hsize, hburst;
   logic [1:0][3:0] hprot;
   logic [31:0] mm [2][16];
   tr_t q[$];
   int n_tests = 0;
   int n_fail = 0;
   always #5 hclk = ~hclk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      ahb_lite_sram_slave #(.WAIT_STATES(2*g)) dut (
         .hclk    (hclk),
         .hresetn (hresetn),
         .hsel    (hsel[g]),
         .haddr   (haddr[g]),
         .htrans  (htrans[g]),
         .hwrite  (hwrite[g]),
         .hsize   (hsize[g]),
         .hburst  (hburst[g]),
         .hprot   (hprot[g]),
         .hwdata  (hwdata[g]),
         .error   (error[g]),
         .hrdata  (hrdata[g]),
         .hready  (hready[g]),
         .hresp   (hresp[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   function automatic tr_t mk(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                              input logic err, input logic [31:0] addr, input logic [31:0] data);
      return {sel, trans, wr, size, err, addr, data};
   endfunction
   function automatic bit is_bad(input tr_t t);
      return t.err || t.addr >= 32'd1024 || t.size > 3'd2 || (t.addr % (32'd1 << t.size)) != 0;
   endfunction
   // Drives q as a pipelined stream on instance k and checks every cycle against the model.
   task automatic run(input int k);
      tr_t t, d;
      bit dv, d_err;
      logic rdy;
      int cyc, len, i, lane;
      dv = 0; d_err = 0; cyc = 0; len = 0; i = 0; d = '0;
      while (i < q.size() || dv) begin
         t = (i < q.size()) ? q[i] : mk(1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
         hsel[k] = t.sel; haddr[k] = t.addr; htrans[k] = t.trans; hwrite[k] = t.wr;
         hsize[k] = t.size; error[k] = t.err;
         hburst[k] = 3'($urandom); hprot[k] = 4'($urandom);
         hwdata[k] = dv ? d.data : $urandom;
         @(negedge hclk);
         rdy = hready[k];
         if (dv) begin
            cyc++;
            check($sformatf("hready k%0d a%h c%0d", k, d.addr, cyc), 32'(rdy), 32'(cyc == len));
            check($sformatf("hresp k%0d a%h", k, d.addr), 32'(hresp[k]), d_err ? 32'd1 : 32'd0);
            if (!d_err) check($sformatf("hrdata k%0d a%h w%0d", k, d.addr, d.wr), hrdata[k],
                              d.wr ? 32'd0 : mm[k][d.addr[5:2]]);
            if (cyc > 20) begin
               n_tests++; n_fail++;
               $display("FAIL timeout k%0d: data phase still open after %0d cycles", k, cyc);
               q.delete();
               return;
            end
         end else begin
            check($sformatf("idle_hready k%0d", k), 32'(rdy), 32'd1);
            check($sformatf("idle_hresp k%0d", k), 32'(hresp[k]), 32'd0);
            check($sformatf("idle_hrdata k%0d", k), hrdata[k], 32'd0);
         end
         @(posedge hclk); #1;
         if (rdy) begin
            if (dv && !d_err && d.wr)
               for (int b = 0; b < (1 << d.size); b++) begin
                  lane = int'(d.addr[1:0]) + b;
                  mm[k][d.addr[5:2]][8*lane +: 8] = d.data[8*lane +: 8];
               end
            dv = 0;
            if (i < q.size()) begin
               if (t.sel && t.trans[1]) begin
                  d = t; dv = 1; cyc = 0;
                  d_err = is_bad(t);
                  len = d_err ? 2 : 2*k + 1;
               end
               i++;
            end
         end
      end
      q.delete();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      hsel = '0; haddr = '0; htrans = '0; hwrite = '0; hsize = '0;
      hburst = '0; hprot = '0; hwdata = '0; error = '0;
      hresetn = 1'b0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_hready k%0d", k), 32'(hready[k]), 32'd1);
         check($sformatf("reset_hresp k%0d", k), 32'(hresp[k]), 32'd0);
         check($sformatf("reset_hrdata k%0d", k), hrdata[k], 32'd0);
      end
      @(posedge hclk); #1;
      hresetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 16; w++) q.push_back(mk(1'b1, NS, 1'b1, 3'd2, 1'b0, 32'(w*4), $urandom));
         q.push_back(mk(1'b1, NS, 1'b1, 3'd2, 1'b0, 32'h10, 32'hDEADBEEF));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h10, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h0, 32'd0));
         q.push_back(mk(1'b1, 2'b11, 1'b0, 3'd2, 1'b0, 32'h4, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b1, 3'd2, 1'b0, 32'h10, 32'h11223344));
         q.push_back(mk(1'b1, NS, 1'b1, 3'd0, 1'b0, 32'h13, 32'hAA000000));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h10, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b1, 3'd2, 1'b1, 32'h20, 32'hCAFEF00D));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h20, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'd1024, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b1, 3'd1, 1'b0, 32'h1, 32'h12345678));
         q.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 1'b0, 32'h8, 32'h0));
         q.push_back(mk(1'b1, 2'b01, 1'b1, 3'd2, 1'b0, 32'h8, 32'h0));
         q.push_back(mk(1'b0, NS, 1'b1, 3'd2, 1'b0, 32'h8, 32'h0));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd3, 1'b0, 32'h8, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h1, 32'd0));
         q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h1C, 32'd0));
         for (int j = 0; j < 60; j++) begin
            int r;
            r = $urandom_range(0, 15);
            q.push_back(mk(1'(r != 0), 2'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                           1'($urandom_range(0, 7) == 0),
                           (r == 1) ? 32'(1024 + $urandom_range(0, 255)) : 32'($urandom_range(0, 63)),
                           $urandom));
         end
         run(k);
      end
      hsel[1] = 1'b1; haddr[1] = 32'h8; htrans[1] = NS; hwrite[1] = 1'b1; hsize[1] = 3'd2; error[1] = 1'b0;
      @(posedge hclk); #1;
      hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h5555AAAA;
      @(negedge hclk);
      check("abort_in_wait", 32'(hready[1]), 32'd0);
      hresetn = 1'b0;
      #1;
      check("abort_hready", 32'(hready[1]), 32'd1);
      check("abort_hresp", 32'(hresp[1]), 32'd0);
      check("abort_hrdata", hrdata[1], 32'd0);
      @(posedge hclk); #1;
      hresetn = 1'b1;
      q.push_back(mk(1'b1, NS, 1'b0, 3'd2, 1'b0, 32'h8, 32'd0));
      run(1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
